// File: rtl/button_reader.sv
// Push-button front end: two-flop synchroniser, counter-based debounce FSM,
// registered clean level plus press/release/long-press pulses.
module button_reader #(
    parameter int DBITS      = 16,
    parameter int DEBOUNCE   = 50000,
    parameter int LBITS      = 26,
    parameter int LONGPRESS  = 24000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    // state   | meaning
    // UP      | button released and accepted as released
    // DB_DOWN | pressed level seen, counting stable cycles before accepting
    // DOWN    | button pressed and accepted as pressed
    // DB_UP   | released level seen, counting stable cycles before accepting
    typedef enum logic [1:0] {UP, DB_DOWN, DOWN, DB_UP} state_t;

    localparam logic [DBITS-1:0] DB_LAST = DBITS'(DEBOUNCE - 1);
    localparam logic [LBITS-1:0] LP_MAX  = LBITS'(LONGPRESS);
    localparam logic [LBITS-1:0] LP_PRE  = LBITS'(LONGPRESS - 1);

    state_t           state_q, state_d;
    logic [DBITS-1:0] dcnt_q, dcnt_d;
    logic [LBITS-1:0] lcnt_q, lcnt_d;
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             lcnt_adv;
    logic             s;

    assign s = sync2_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= UP;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= i_btn ^ ACTIVE_LOW;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        lcnt_adv  = 1'b0;
        case (state_q)
            UP: begin
                if (s) begin
                    state_d = DB_DOWN;
                    dcnt_d  = '0;
                end
            end
            DB_DOWN: begin
                if (!s) begin
                    state_d = UP;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = DOWN;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    lcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DBITS'(1);
                end
            end
            DOWN: begin
                lcnt_adv = 1'b1;
                if (!s) begin
                    state_d = DB_UP;
                    dcnt_d  = '0;
                end
            end
            DB_UP: begin
                // the hold timer keeps running while a release is still unconfirmed
                if (s) begin
                    state_d  = DOWN;
                    lcnt_adv = 1'b1;
                end else if (dcnt_q == DB_LAST) begin
                    state_d   = UP;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d   = dcnt_q + DBITS'(1);
                    lcnt_adv = 1'b1;
                end
            end
            default: state_d = UP;
        endcase
        if (lcnt_adv && (lcnt_q != LP_MAX)) begin
            lcnt_d = lcnt_q + LBITS'(1);
            long_d = (lcnt_q == LP_PRE);
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
endmodule
